fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage feeding the decoder, and through it the decode/execute pipeline latch. Keeps the program counter and issues single-outstanding word reads to instruction memory over a req/ack handshake. Buffers returned words with their PCs in a small prefetch FIFO and presents the head to the decoder. Honours jump redirects from the execute stage by flushing the buffer and discarding any in-flight read.

## Interface
- `DEPTH`, default 4: prefetch FIFO entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_req` out 1: read request; held until `mem_ack`.
- `mem_addr` out 32: word address of the request; stable while `mem_req`=1.
- `mem_ack` in 1: read complete; `mem_data` valid this cycle.
- `mem_data` in 32: returned instruction word.
- `jmp_take` in 1: one-cycle redirect pulse from execute.
- `jmp_target` in 32: redirect address, sampled when `jmp_take`=1.
- `dec_ready` in 1: decoder accepts the head word (the downstream latch enable).
- `instr_valid` out 1: FIFO non-empty.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: PC of the head word.
- `fetch_fault` out 1: sticky misaligned-target flag; present only with `FETCH_ALIGN_CHECK_EN`.

## Operation
- State: `fetch_pc`, FIFO of {word, pc}, `count` (0..DEPTH), FSM {IDLE, WAIT, DRAIN}.
- Reset values: `mem_req`=0, `mem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0 (while empty), `fetch_pc`=RESET_PC, `count`=0, state IDLE, `fetch_fault`=0.
- IDLE: if `count` < DEPTH and no `jmp_take`, assert `mem_req` with `mem_addr`=`fetch_pc`, go to WAIT.
- WAIT: hold `mem_req` and `mem_addr`. On `mem_ack`, push {`mem_data`, `mem_addr`}, `fetch_pc` += 4 (mod 2^32, wraps silently). Then issue the next request back-to-back if space remains after this cycle's push/pop, otherwise go to IDLE.
- Issue rule: a request starts only when `count` + 1 <= DEPTH after the current push/pop, so a push never overflows.
- Pop: when `instr_valid` && `dec_ready`. Push and pop in the same cycle keep `count` unchanged.
- Redirect (`jmp_take`=1): flush FIFO (`count`=0) and set `fetch_pc`=`jmp_target`; any same-cycle pop or push is discarded.
  - In IDLE, or in WAIT with `mem_ack`=1: next request to `jmp_target` issues the following cycle.
  - In WAIT with `mem_ack`=0: go to DRAIN.
- DRAIN: keep `mem_req`/old `mem_addr` until `mem_ack`. Discard the data, then issue `jmp_target`. A further `jmp_take` in DRAIN overwrites `fetch_pc` only.
- Reset mid-transaction: `mem_req` drops next edge. A late `mem_ack` in IDLE is ignored.

## Timing
- `mem_ack` may arrive in the same cycle `mem_req` rises. There is at most one outstanding request.
- `mem_ack` at cycle N: `instr_valid`=1 at N+1 (head updated at N+1).
- `jmp_take` at cycle N: `instr_valid`=0 at N+1. `mem_req` with `mem_addr`=`jmp_target` at N+1, or at the cycle after the drained ack.
- Zero-wait memory: sustained throughput of one word per cycle when `dec_ready`=1.
- First request: cycle after `reset` deasserts.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - `jmp_take` with `jmp_target[1:0]`≠0 sets `fetch_fault` (cleared only by `reset`).
  - Fetching halts in IDLE after the flush.
- Undefined: `jmp_target[1:0]` is forced to 0, no halt, and the `fetch_fault` port is absent.

## Test plan
- Reset release, memory acks every cycle, `dec_ready`=1 -> `mem_addr` 0,4,8,…; `instr_pc` sequence 0,4,8 starting the cycle after the first ack.
- `dec_ready`=0 with acks every cycle -> exactly 4 pushes (DEPTH=4), `mem_req` low afterwards. `dec_ready`=1 for one cycle -> one pop, one new request.
- Memory with 3-cycle ack latency, `jmp_take` target 32'h100 one cycle after req -> DRAIN, old data dropped, `instr_valid` stays 0 until word at 0x100 is returned with `instr_pc`=0x100.
- `jmp_take` in the same cycle as `mem_ack` and pop -> FIFO empty next cycle, next `mem_addr`=target.
- `fetch_pc`=32'hFFFF_FFFC fetch -> next `mem_addr`=0.
- With `FETCH_ALIGN_CHECK_EN`, target 32'h102 -> `fetch_fault`=1, no further `mem_req`. Without the macro -> fetch from 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Program counter, single-outstanding instruction fetch and prefetch
//            FIFO. Optional macro FETCH_ALIGN_CHECK_EN adds a misaligned-jump
//            fault flag (fetch_fault) that halts fetching.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        jmp_take,
  input  logic [31:0] jmp_target,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_word [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [31:0]   w_target;
  logic          w_halt;
  logic          w_halt_next;
  logic          w_pop;
  logic          w_push;
  logic          w_can_issue;
  logic [CW-1:0] w_count_next;
  logic [31:0]   w_pc_inc;
  logic [31:0]   w_drain_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;
  assign w_target    = jmp_target;
  assign w_halt      = r_fault;
  assign w_halt_next = r_fault | (jmp_take & (jmp_target[1:0] != 2'b00));
  assign fetch_fault = r_fault;
`else
  logic w_unused_lsb;
  assign w_target     = {jmp_target[31:2], 2'b00};
  assign w_halt       = 1'b0;
  assign w_halt_next  = 1'b0;
  assign w_unused_lsb = ^jmp_target[1:0];
`endif

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_word[r_rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? r_pc[r_rd_ptr]   : 32'h0;

  // A redirect swallows any same-cycle push or pop.
  assign w_pop        = instr_valid & dec_ready & ~jmp_take;
  assign w_push       = (r_state == S_WAIT) & mem_ack & ~jmp_take;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_can_issue  = (w_count_next < C_DEPTH) & ~w_halt;
  assign w_pc_inc     = r_mem_addr + 32'd4;
  assign w_drain_pc   = jmp_take ? w_target : r_fetch_pc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_word[r_wr_ptr] <= mem_data;
      r_pc[r_wr_ptr]   <= r_mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      if (jmp_take) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_fetch_pc <= w_target;
`ifdef FETCH_ALIGN_CHECK_EN
        r_fault    <= w_halt_next;
`endif
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= w_count_next;
      end

      case (r_state)
        S_IDLE: begin
          if (jmp_take) begin
            if (!w_halt_next) begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_target;
              r_state    <= S_WAIT;
            end
          end else if (w_can_issue) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (jmp_take) begin
              if (!w_halt_next) begin
                r_mem_addr <= w_target;
              end else begin
                r_mem_req <= 1'b0;
                r_state   <= S_IDLE;
              end
            end else begin
              r_fetch_pc <= w_pc_inc;
              if (w_can_issue) begin
                r_mem_addr <= w_pc_inc;
              end else begin
                r_mem_req <= 1'b0;
                r_state   <= S_IDLE;
              end
            end
          end else if (jmp_take) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The stale word is dropped; the redirect target is fetched next.
          if (mem_ack) begin
            if (!w_halt_next) begin
              r_mem_addr <= w_drain_pc;
              r_state    <= S_WAIT;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
